// File: rtl/intc85_pkg.sv
// Shared types and constants for the core85 8-input interrupt controller.
package intc85_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_IMR = 2'd0;
    localparam logic [1:0] ADDR_EOI = 2'd1;
    localparam logic [1:0] ADDR_IRR = 2'd2;
    localparam logic [1:0] ADDR_ISR = 2'd3;

    localparam logic [7:0] RST_BASE     = 8'hC7;
    localparam int         EOI_SPECIFIC = 7;

    // Position of idx in the priority order that starts at base (0 = highest).
    function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] base);
        return idx - base;
    endfunction

endpackage

// File: rtl/intc85_prienc.sv
// 8-bit priority encoder: returns the first set bit of req scanning upward
// from base with wrap-around; base = 0 gives plain lowest-index priority.
module intc85_prienc (
    input  logic [7:0] req,
    input  logic [2:0] base,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the lowest priority upward so the highest-priority hit lands last.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[base + 3'(i)]) begin
                idx = base + 3'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/intc85_ctrl.sv
// Priority interrupt controller for core85: latches irq edges, masks, nests,
// and answers INTA with an RST n opcode. Define ROTATE_PRIO_EN for rotating priority.
//
// state | meaning
// IDLE  | no eligible request, intr low
// REQ   | intr raised, waiting for the core to start INTA
// ACK   | vector driven while inta_ is low
// DONE  | one quiet cycle before returning to IDLE
module intc85_ctrl
    import intc85_pkg::*;
#(
    parameter int         NIRQ    = 8,
    parameter logic [7:0] RSTBASE = RST_BASE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    output logic            intr,
    input  logic            inta_,
    output logic [7:0]      vec_data,
    output logic            vec_oe,
    input  logic            cfg_wr,
    input  logic            cfg_rd,
    input  logic [1:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic [7:0]      cfg_rdata
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] irq_q;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;
    logic [7:0] cand;
    logic [7:0] isr_clr;
    logic [2:0] vsel;
    logic [2:0] win_idx;
    logic [2:0] isr_idx;
    logic [2:0] pbase_w;
    logic       win_valid;
    logic       isr_valid;
    logic       eligible;
    logic       inta_q;
    logic       ack_start;
    logic       ack_take;
    logic       ack_grant;
    logic       eoi_wr;
    logic       intr_d;

    assign cand      = irr & ~imr;
    assign ack_start = inta_q & ~inta_;
    assign ack_take  = (state == ST_REQ) && ack_start;
    assign ack_grant = ack_take && eligible;
    assign eoi_wr    = cfg_wr && (cfg_addr == ADDR_EOI);

`ifdef ROTATE_PRIO_EN
    logic [2:0] pbase;

    always_ff @(posedge clk) begin
        if (rst) begin
            pbase <= 3'd0;
        end else if (eoi_wr && !cfg_wdata[EOI_SPECIFIC] && isr_valid) begin
            pbase <= isr_idx + 3'd1;
        end
    end

    assign pbase_w = pbase;
`else
    assign pbase_w = 3'd0;
`endif

    intc85_prienc u_win_enc (
        .req   (cand),
        .base  (pbase_w),
        .idx   (win_idx),
        .valid (win_valid)
    );

    intc85_prienc u_isr_enc (
        .req   (isr),
        .base  (pbase_w),
        .idx   (isr_idx),
        .valid (isr_valid)
    );

    assign eligible = win_valid &&
                      (!isr_valid || (prio_rank(win_idx, pbase_w) < prio_rank(isr_idx, pbase_w)));

    always_comb begin
        isr_clr = 8'h00;
        if (eoi_wr) begin
            if (cfg_wdata[EOI_SPECIFIC]) begin
                isr_clr = 8'd1 << cfg_wdata[2:0];
            end else if (isr_valid) begin
                isr_clr = 8'd1 << isr_idx;
            end
        end
    end

    // The acknowledge clear is applied before new edges so a fresh edge on the same line survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q  <= 8'h00;
            inta_q <= 1'b1;
            irr    <= 8'h00;
            isr    <= 8'h00;
            imr    <= 8'hFF;
            vsel   <= 3'd0;
        end else begin
            irq_q  <= irq;
            inta_q <= inta_;
            irr    <= (ack_grant ? (irr & ~(8'd1 << win_idx)) : irr) | (irq & ~irq_q);
            isr    <= (isr & ~isr_clr) | (ack_grant ? (8'd1 << win_idx) : 8'h00);
            if (cfg_wr && (cfg_addr == ADDR_IMR)) begin
                imr <= cfg_wdata;
            end
            if (ack_take) begin
                vsel <= eligible ? win_idx : 3'd7;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= 8'h00;
        end else if (cfg_rd) begin
            case (cfg_addr)
                ADDR_IMR: cfg_rdata <= imr;
                ADDR_IRR: cfg_rdata <= irr;
                ADDR_ISR: cfg_rdata <= isr;
                default:  cfg_rdata <= 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            intr  <= 1'b0;
        end else begin
            state <= state_nxt;
            intr  <= intr_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (eligible) state_nxt = ST_REQ;
            ST_REQ: begin
                if (ack_start) begin
                    state_nxt = ST_ACK;
                end else if (!eligible) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACK:  if (inta_) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // intr only stays up while REQ persists, so it falls with the move to ACK or IDLE.
    always_comb begin
        intr_d   = (state == ST_REQ) && (state_nxt == ST_REQ);
        vec_oe   = (state == ST_ACK);
        vec_data = vec_oe ? (RSTBASE | {vsel, 3'b000}) : 8'h00;
    end

endmodule

// File: tb/tb_intc85_ctrl.sv
// Self-checking bench for intc85_ctrl; vectors are scoreboarded against the
// order the requests should be served, register state is checked directly.
module tb_intc85_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic       intr;
    logic       inta_;
    logic [7:0] vec_data;
    logic       vec_oe;
    logic       cfg_wr;
    logic       cfg_rd;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];
    logic       oe_prev  = 1'b0;

    intc85_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .intr      (intr),
        .inta_     (inta_),
        .vec_data  (vec_data),
        .vec_oe    (vec_oe),
        .cfg_wr    (cfg_wr),
        .cfg_rd    (cfg_rd),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every new vector window pops the next expected opcode.
    always @(negedge clk) begin
        if (vec_oe && !oe_prev) begin
            if (sb_q.size() == 0) begin
                check_eq("vec_unexpected", {24'h0, vec_data}, 32'hFFFF_FFFF);
            end else begin
                check_eq("vec_data", {24'h0, vec_data}, {24'h0, sb_q.pop_front()});
            end
        end
        oe_prev <= vec_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cfg_rd   = 1'b1;
        cfg_addr = a;
        tick();
        cfg_rd   = 1'b0;
        check_eq(tag, {24'h0, cfg_rdata}, {24'h0, exp});
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq = irq | m;
        tick();
        irq = irq & ~m;
    endtask

    task automatic wait_intr(input string tag);
        int n = 0;
        while (!intr && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, {31'h0, intr}, 32'h1);
    endtask

    task automatic do_ack(input string tag);
        check_eq({tag, "_intr"}, {31'h0, intr}, 32'h1);
        inta_ = 1'b0;
        tick();
        check_eq({tag, "_oe"}, {31'h0, vec_oe}, 32'h1);
        check_eq({tag, "_intr_lo"}, {31'h0, intr}, 32'h0);
        tick();
        check_eq({tag, "_hold"}, {31'h0, vec_oe}, 32'h1);
        inta_ = 1'b1;
        tick();
        check_eq({tag, "_done"}, {31'h0, vec_oe}, 32'h0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        irq       = 8'h00;
        inta_     = 1'b1;
        cfg_wr    = 1'b0;
        cfg_rd    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_eq("rst_intr", {31'h0, intr}, 32'h0);
        check_eq("rst_oe", {31'h0, vec_oe}, 32'h0);
        check_eq("rst_vec", {24'h0, vec_data}, 32'h0);
        check_eq("rst_rdata", {24'h0, cfg_rdata}, 32'h0);
        chk_reg("rst_imr", 2'd0, 8'hFF);
        chk_reg("rst_irr", 2'd2, 8'h00);
        chk_reg("rst_isr", 2'd3, 8'h00);
        chk_reg("rd_eoi", 2'd1, 8'h00);

        // single request, latency and vector
        cfg_write(2'd0, 8'h00);
        sb_q.push_back(8'hDF);
        pulse_irq(8'h08);
        check_eq("lat_e1", {31'h0, intr}, 32'h0);
        tick();
        check_eq("lat_e2", {31'h0, intr}, 32'h0);
        tick();
        check_eq("lat_e3", {31'h0, intr}, 32'h1);
        repeat (2) tick();
        do_ack("ack3");
        chk_reg("isr_08", 2'd3, 8'h08);
        chk_reg("irr_00", 2'd2, 8'h00);
        cfg_write(2'd1, 8'h00);
        chk_reg("isr_eoi", 2'd3, 8'h00);

        // two simultaneous requests served in priority order
        sb_q.push_back(8'hD7);
        sb_q.push_back(8'hEF);
        pulse_irq(8'h24);
        wait_intr("w_2");
        do_ack("ack2");
        chk_reg("isr_04", 2'd3, 8'h04);
        chk_reg("irr_20", 2'd2, 8'h20);
        check_eq("nest_block5", {31'h0, intr}, 32'h0);
        cfg_write(2'd1, 8'h00);
        wait_intr("w_5");
        do_ack("ack5");
        cfg_write(2'd1, 8'h00);

        // nesting: lower priority request waits for EOI
        sb_q.push_back(8'hD7);
        pulse_irq(8'h04);
        wait_intr("w_n2");
        do_ack("ackn2");
        pulse_irq(8'h40);
        repeat (4) tick();
        check_eq("nest_block6", {31'h0, intr}, 32'h0);
        sb_q.push_back(8'hF7);
        cfg_write(2'd1, 8'h00);
        wait_intr("w_6");
        do_ack("ack6");
        cfg_write(2'd1, 8'h00);
        chk_reg("isr_clean", 2'd3, 8'h00);

        // masking and withdrawal before acknowledge
        cfg_write(2'd0, 8'hFF);
        pulse_irq(8'h02);
        repeat (4) tick();
        check_eq("mask_intr", {31'h0, intr}, 32'h0);
        chk_reg("mask_irr", 2'd2, 8'h02);
        cfg_write(2'd0, 8'hFD);
        wait_intr("w_unmask");
        cfg_write(2'd0, 8'hFF);
        repeat (2) tick();
        check_eq("withdraw_intr", {31'h0, intr}, 32'h0);
        chk_reg("withdraw_irr", 2'd2, 8'h02);

        // spurious: mask lands just before INTA while intr is still high
        cfg_write(2'd0, 8'hFD);
        wait_intr("w_sp");
        sb_q.push_back(8'hFF);
        cfg_write(2'd0, 8'hFF);
        do_ack("ack_sp");
        chk_reg("sp_isr", 2'd3, 8'h00);
        chk_reg("sp_irr", 2'd2, 8'h02);
        sb_q.push_back(8'hCF);
        cfg_write(2'd0, 8'hFD);
        wait_intr("w_1");
        do_ack("ack1");
        cfg_write(2'd1, 8'h00);

        // priority order after a non-specific EOI
        cfg_write(2'd0, 8'h00);
        sb_q.push_back(8'hCF);
        pulse_irq(8'h02);
        wait_intr("w_r1");
        do_ack("ackr1");
        cfg_write(2'd1, 8'h00);
`ifdef ROTATE_PRIO_EN
        sb_q.push_back(8'hD7);
        sb_q.push_back(8'hC7);
`else
        sb_q.push_back(8'hC7);
        sb_q.push_back(8'hD7);
`endif
        pulse_irq(8'h05);
        wait_intr("w_ra");
        do_ack("ackra");
        cfg_write(2'd1, 8'h00);
        wait_intr("w_rb");
        do_ack("ackrb");
`ifdef ROTATE_PRIO_EN
        cfg_write(2'd1, 8'h80);
`else
        cfg_write(2'd1, 8'h82);
`endif
        chk_reg("spec_eoi_isr", 2'd3, 8'h00);

        // reset in the middle of an acknowledge
        sb_q.push_back(8'hE7);
        pulse_irq(8'h10);
        wait_intr("w_4");
        inta_ = 1'b0;
        tick();
        check_eq("mid_ack_oe", {31'h0, vec_oe}, 32'h1);
        rst = 1'b1;
        tick();
        check_eq("rst_ack_oe", {31'h0, vec_oe}, 32'h0);
        check_eq("rst_ack_intr", {31'h0, intr}, 32'h0);
        rst   = 1'b0;
        inta_ = 1'b1;
        tick();
        chk_reg("rst_ack_imr", 2'd0, 8'hFF);
        chk_reg("rst_ack_isr", 2'd3, 8'h00);
        chk_reg("rst_ack_irr", 2'd2, 8'h00);

        tick();
        check_eq("sb_empty", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
